multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
- Control side of the MIPS datapath interface: consumes op/funct/zero from the datapath and produces every datapath control select.
- Converts the datapath into a multi-cycle machine with a per-instruction FSM.
- Stretches load/store memory phases with a request/ready handshake.
- Counts retired instructions and flags illegal encodings.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- op  in  6  instr[31:26] from the datapath IR.
- funct  in  6  instr[5:0] from the datapath IR.
- zero  in  1  ALU equality flag, same-cycle combinational.
- mem_ready  in  1  data memory completes the current access this cycle.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  instruction register load enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write strobe.
- mem_req  out  1  data memory access request.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  00 ALU, 01 memory, 10 PC+4.
- ALUOp  out  4  0000 ADD, 0001 SUB, 0010 OR, 0011 SLL, 0100 LUI.
- ALUSrc  out  1  0 register, 1 imm32.
- ExtOp  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16.
- Jump  out  2  00 sequential/branch, 01 j/jal target, 10 jr register.
- Branch_sel  out  2  00 none, 01 branch-if-zero.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- instr_cnt  out  CNT_W  retired instruction count.

Behaviour:
- Supported instructions:
  - R-type (op 000000) with funct addu 100001, subu 100011, sll 000000, jr 001000.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States: IDLE, FETCH, DECODE, EXE_R, EXE_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_LD, BRANCH, JUMP.
- Reset (reset=0): state=IDLE, instr_cnt=0; all outputs 0 (selects 00). Reset takes effect mid-instruction and mid-handshake; the partial instruction is abandoned, no retire.
- IDLE -> FETCH unconditionally; all outputs 0.
- FETCH: IRWrite=1, PCWrite=1 (PC+4) -> DECODE.
- DECODE:
  - Latch the instruction class from op/funct into an internal register; outputs must not depend on live op/funct after this point.
  - Next state by class:
    - addu/subu/sll -> EXE_R; ori/lui -> EXE_I; lw/sw -> MEM_ADDR; beq -> BRANCH; j/jal/jr -> JUMP.
    - Illegal -> FETCH with illegal=1; no retire and no count increment.
- EXE_R: ALUSrc=0; ALUOp ADD/SUB/SLL -> WB_R.
- WB_R: RegDst=01, MemtoReg=00, RegWrite=1, ALU selects held -> FETCH, retire.
- EXE_I: ALUSrc=1; ori: ExtOp=00, ALUOp=OR; lui: ExtOp=10, ALUOp=LUI -> WB_I.
- WB_I: RegDst=00, RegWrite=1, EXE_I selects held -> FETCH, retire.
- MEM_ADDR: ALUSrc=1, ExtOp=01, ALUOp=ADD -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD / MEM_WR: mem_req=1; MEM_WR also MemWrite=1; address selects held.
  - Stay while mem_ready=0; every output remains bit-identical each waiting cycle.
  - mem_ready=1: MEM_RD -> WB_LD; MEM_WR -> FETCH with retire.
  - mem_ready high outside MEM_RD/MEM_WR is ignored.
- WB_LD: RegDst=00, MemtoReg=01, RegWrite=1 -> FETCH, retire.
- BRANCH: ALUSrc=0, ALUOp=SUB, Branch_sel=01, ExtOp=01, PCWrite=zero -> FETCH, retire.
- JUMP:
  - j: Jump=01, PCWrite=1.
  - jal: also RegDst=10, MemtoReg=10, RegWrite=1.
  - jr: Jump=10, PCWrite=1.
  - -> FETCH, retire.
- Latency (cycles, FETCH to retire inclusive): R/ori/lui 4; sw 4+wait; lw 5+wait; beq/j/jal/jr 3.
- retire and the instr_cnt increment occur on the same edge; the count wraps from all-ones to 0.
- RegWrite and MemWrite are never both 1; PCWrite is never 1 outside FETCH/BRANCH/JUMP.

Decomposition:
- ctrl_pkg holds:
  - state enum;
  - opcode/funct constants;
  - ALUOp, RegDst, MemtoReg, ExtOp and Jump encodings;
  - instruction-class enum.
- Sub-module ctrl_decode: combinational op/funct -> class plus illegal flag; instantiated once in multi_cycle_ctrl.

Test Plan:
- Reset low for 3 cycles, then high -> all outputs 0 during reset and in IDLE; FETCH next cycle with IRWrite=1, PCWrite=1; instr_cnt=0.
- addu (op 0, funct 100001) -> RegWrite=1, RegDst=01 only in the 4th cycle; retire pulse; instr_cnt=1.
- lw with mem_ready held low 3 cycles in MEM_RD -> mem_req=1 for 4 cycles with outputs stable; WB_LD has MemtoReg=01, RegWrite=1; total 8 cycles.
- beq with zero=1, then beq with zero=0 -> PCWrite=1 in BRANCH for the first, 0 for the second; both retire in 3 cycles.
- jal -> JUMP has Jump=01, RegDst=10, MemtoReg=10, RegWrite=1, PCWrite=1; jr -> Jump=10, RegWrite=0.
- Illegal op 111111 -> illegal pulse in DECODE; returns to FETCH; instr_cnt unchanged. Reset asserted during MEM_WR wait -> IDLE immediately, mem_req/MemWrite drop asynchronously.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller:
// FSM states, opcode/funct values, datapath select codes, instruction classes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXE_R,
    S_EXE_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_R,
    S_WB_I,
    S_WB_LD,
    S_BRANCH,
    S_JUMP
  } state_e;

  typedef enum logic [3:0] {
    C_ADDU,
    C_SUBU,
    C_SLL,
    C_JR,
    C_ORI,
    C_LUI,
    C_LW,
    C_SW,
    C_BEQ,
    C_J,
    C_JAL,
    C_ILL
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b0100;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_PC4  = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] JMP_SEQ  = 2'b00;
  localparam logic [1:0] JMP_TGT  = 2'b01;
  localparam logic [1:0] JMP_REG  = 2'b10;

  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_ZERO  = 2'b01;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational op/funct classifier.
// Ports: op, funct in; cls (instruction class), illegal out.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_e       cls,
  output logic       illegal
);

  always_comb begin
    cls = C_ILL;
    unique case (op)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADDU: cls = C_ADDU;
          FN_SUBU: cls = C_SUBU;
          FN_SLL:  cls = C_SLL;
          FN_JR:   cls = C_JR;
          default: cls = C_ILL;
        endcase
      end
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILL;
    endcase
    illegal = (cls == C_ILL);
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: drives all datapath selects from op/funct/zero,
// handshakes memory phases, pulses retire/illegal, counts retired instructions.
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             mem_req,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic [3:0]       ALUOp,
  output logic             ALUSrc,
  output logic [1:0]       ExtOp,
  output logic [1:0]       Jump,
  output logic [1:0]       Branch_sel,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  cls_e             dec_cls;
  logic             dec_ill;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_decode u_dec (
    .op      (op),
    .funct   (funct),
    .cls     (dec_cls),
    .illegal (dec_ill)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cls_q   <= C_ILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    mem_req    = 1'b0;
    RegDst     = RD_RT;
    MemtoReg   = M2R_ALU;
    ALUOp      = ALU_ADD;
    ALUSrc     = 1'b0;
    ExtOp      = EXT_ZERO;
    Jump       = JMP_SEQ;
    Branch_sel = BR_NONE;
    retire     = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Only cycle that looks at live op/funct.
        cls_d   = dec_cls;
        illegal = dec_ill;
        unique case (dec_cls)
          C_ADDU, C_SUBU, C_SLL: state_d = S_EXE_R;
          C_ORI, C_LUI:          state_d = S_EXE_I;
          C_LW, C_SW:            state_d = S_MEM_ADDR;
          C_BEQ:                 state_d = S_BRANCH;
          C_J, C_JAL, C_JR:      state_d = S_JUMP;
          default:               state_d = S_FETCH;
        endcase
      end
      S_EXE_R, S_WB_R: begin
        ALUOp = (cls_q == C_SUBU) ? ALU_SUB :
                (cls_q == C_SLL)  ? ALU_SLL : ALU_ADD;
        if (state_q == S_WB_R) begin
          RegDst   = RD_RD;
          RegWrite = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_WB_R;
        end
      end
      S_EXE_I, S_WB_I: begin
        ALUSrc = 1'b1;
        ExtOp  = (cls_q == C_LUI) ? EXT_LUI : EXT_ZERO;
        ALUOp  = (cls_q == C_LUI) ? ALU_LUI : ALU_OR;
        if (state_q == S_WB_I) begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_WB_I;
        end
      end
      S_MEM_ADDR, S_MEM_RD, S_MEM_WR: begin
        ALUSrc = 1'b1;
        ExtOp  = EXT_SIGN;
        ALUOp  = ALU_ADD;
        if (state_q == S_MEM_ADDR) begin
          state_d = (cls_q == C_SW) ? S_MEM_WR : S_MEM_RD;
        end else begin
          mem_req  = 1'b1;
          MemWrite = (state_q == S_MEM_WR);
          if (mem_ready) begin
            retire  = (state_q == S_MEM_WR);
            state_d = (state_q == S_MEM_WR) ? S_FETCH : S_WB_LD;
          end
        end
      end
      S_WB_LD: begin
        MemtoReg = M2R_MEM;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUOp      = ALU_SUB;
        ExtOp      = EXT_SIGN;
        Branch_sel = BR_ZERO;
        PCWrite    = zero;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        Jump    = (cls_q == C_JR) ? JMP_REG : JMP_TGT;
        if (cls_q == C_JAL) begin
          RegDst   = RD_RA;
          MemtoReg = M2R_PC4;
          RegWrite = 1'b1;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: vector table per instruction,
// scoreboard of expected retire bundles, plus reset corner sequences.
module tb_multi_cycle_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    op, funct;
  logic          zero, mem_ready;
  logic          PCWrite, IRWrite, RegWrite, MemWrite, mem_req;
  logic [1:0]    RegDst, MemtoReg, ExtOp, Jump, Branch_sel;
  logic [3:0]    ALUOp;
  logic          ALUSrc, retire, illegal;
  logic [CW-1:0] instr_cnt;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .mem_req    (mem_req),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ALUOp      (ALUOp),
    .ALUSrc     (ALUSrc),
    .ExtOp      (ExtOp),
    .Jump       (Jump),
    .Branch_sel (Branch_sel),
    .retire     (retire),
    .illegal    (illegal),
    .instr_cnt  (instr_cnt)
  );

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          waits;
    logic        mem;
    logic        ill;
    int          lat;
    logic [19:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    int          lat;
    logic [19:0] exp;
  } sb_t;

  vec_t          tbl[15];
  sb_t           sbq[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_cnt;

  function automatic logic [19:0] mk(
    input logic pcw, rw, mw, req,
    input logic [1:0] rd, m2r,
    input logic [3:0] alu,
    input logic src,
    input logic [1:0] ext, j, b);
    return {pcw, 1'b0, rw, mw, req, rd, m2r, alu, src, ext, j, b};
  endfunction

  function automatic logic [19:0] obs();
    return {PCWrite, IRWrite, RegWrite, MemWrite, mem_req, RegDst,
            MemtoReg, ALUOp, ALUSrc, ExtOp, Jump, Branch_sel};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int          cyc;
    int          mc;
    logic [19:0] hold;
    bit          done;
    sb_t         e;
    op = v.op; funct = v.funct; zero = v.zero; mem_ready = 1'b1;
    #1;
    chk({v.name, " fetch"}, {27'd0, IRWrite, PCWrite, RegWrite,
        MemWrite, mem_req}, 32'b11000);
    if (!v.ill) begin
      e.name = v.name; e.lat = v.lat; e.exp = v.exp;
      sbq.push_back(e);
    end
    cyc = 1; mc = 0; done = 0; hold = '0;
    while (!done && cyc < 40) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      mem_ready = 1'b1;
      if (cyc >= 3) begin op = 6'h3f; funct = 6'h3f; end
      #1;
      if (mem_req) begin
        if (mc == 0) hold = obs();
        else chk({v.name, " memhold"}, {12'd0, obs()}, {12'd0, hold});
        mem_ready = (mc == v.waits);
        mc++;
        #1;
      end
      chk({v.name, " rw_mw"}, {31'd0, RegWrite & MemWrite}, 0);
      chk({v.name, " rw_early"}, {31'd0, RegWrite & ~retire}, 0);
      chk({v.name, " pcw_early"}, {31'd0, PCWrite & ~retire}, 0);
      if (cyc == 2) chk({v.name, " illegal"}, {31'd0, illegal},
                        {31'd0, v.ill});
      if (retire) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s spurious retire at cycle %0d", v.name, cyc);
        end else begin
          e = sbq.pop_front();
          chk({e.name, " latency"}, cyc, e.lat);
          chk({e.name, " bundle"}, {12'd0, obs()}, {12'd0, e.exp});
          chk({e.name, " memcycles"}, mc, v.mem ? v.waits + 1 : 0);
        end
        exp_cnt = exp_cnt + 1'b1;
        done = 1;
      end else if (cyc == 2 && v.ill) begin
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout got no retire want retire", v.name);
    end
    @(posedge clk); @(negedge clk);
    #1;
    chk({v.name, " count"}, {28'd0, instr_cnt}, {28'd0, exp_cnt});
  endtask

  initial begin
    tbl[0]  = '{"addu", 6'h00, 6'h21, 0, 0, 0, 0, 4,
                mk(0,1,0,0,2'b01,2'b00,4'b0000,0,2'b00,2'b00,2'b00)};
    tbl[1]  = '{"subu", 6'h00, 6'h23, 0, 0, 0, 0, 4,
                mk(0,1,0,0,2'b01,2'b00,4'b0001,0,2'b00,2'b00,2'b00)};
    tbl[2]  = '{"sll", 6'h00, 6'h00, 0, 0, 0, 0, 4,
                mk(0,1,0,0,2'b01,2'b00,4'b0011,0,2'b00,2'b00,2'b00)};
    tbl[3]  = '{"ori", 6'h0d, 6'h15, 0, 0, 0, 0, 4,
                mk(0,1,0,0,2'b00,2'b00,4'b0010,1,2'b00,2'b00,2'b00)};
    tbl[4]  = '{"lui", 6'h0f, 6'h00, 0, 0, 0, 0, 4,
                mk(0,1,0,0,2'b00,2'b00,4'b0100,1,2'b10,2'b00,2'b00)};
    tbl[5]  = '{"lw_w3", 6'h23, 6'h04, 0, 3, 1, 0, 8,
                mk(0,1,0,0,2'b00,2'b01,4'b0000,0,2'b00,2'b00,2'b00)};
    tbl[6]  = '{"sw_w1", 6'h2b, 6'h08, 0, 1, 1, 0, 5,
                mk(0,0,1,1,2'b00,2'b00,4'b0000,1,2'b01,2'b00,2'b00)};
    tbl[7]  = '{"beq_z1", 6'h04, 6'h00, 1, 0, 0, 0, 3,
                mk(1,0,0,0,2'b00,2'b00,4'b0001,0,2'b01,2'b00,2'b01)};
    tbl[8]  = '{"beq_z0", 6'h04, 6'h00, 0, 0, 0, 0, 3,
                mk(0,0,0,0,2'b00,2'b00,4'b0001,0,2'b01,2'b00,2'b01)};
    tbl[9]  = '{"j", 6'h02, 6'h00, 0, 0, 0, 0, 3,
                mk(1,0,0,0,2'b00,2'b00,4'b0000,0,2'b00,2'b01,2'b00)};
    tbl[10] = '{"jal", 6'h03, 6'h00, 0, 0, 0, 0, 3,
                mk(1,1,0,0,2'b10,2'b10,4'b0000,0,2'b00,2'b01,2'b00)};
    tbl[11] = '{"jr", 6'h00, 6'h08, 0, 0, 0, 0, 3,
                mk(1,0,0,0,2'b00,2'b00,4'b0000,0,2'b00,2'b10,2'b00)};
    tbl[12] = '{"ill_op", 6'h3f, 6'h21, 0, 0, 0, 1, 0, 20'd0};
    tbl[13] = '{"ill_fn", 6'h00, 6'h20, 0, 0, 0, 1, 0, 20'd0};
    tbl[14] = '{"lw_w0", 6'h23, 6'h00, 0, 0, 1, 0, 5,
                mk(0,1,0,0,2'b00,2'b01,4'b0000,0,2'b00,2'b00,2'b00)};

    reset = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("reset outputs", {12'd0, obs()}, 0);
      chk("reset pulses", {30'd0, retire, illegal}, 0);
      chk("reset count", {28'd0, instr_cnt}, 0);
    end
    reset = 1'b1;
    #1;
    chk("idle outputs", {12'd0, obs()}, 0);
    @(posedge clk); @(negedge clk);

    // Two passes so the 4-bit counter wraps through zero.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 15; i++) run(tbl[i]);

    // Reset while sw is stalled in MEM_WR.
    op = 6'h2b; funct = 6'h00; mem_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sw stall req", {30'd0, mem_req, MemWrite}, 32'b11);
    #2 reset = 1'b0;
    #1;
    chk("async drop", {30'd0, mem_req, MemWrite}, 0);
    chk("async retire", {31'd0, retire}, 0);
    chk("async count", {28'd0, instr_cnt}, 0);
    exp_cnt = '0;
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("reidle outputs", {12'd0, obs()}, 0);
    @(posedge clk); @(negedge clk);
    run(tbl[0]);
    run(tbl[6]);

    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard leftover got %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
